// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a single-port rom256 memory.
// Each access takes IDLE -> ISSUE -> DONE, one cycle per state.
module rom_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_valid,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ready,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_valid,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ready,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // state | meaning
  // IDLE  | sample requests, latch the winner
  // ISSUE | latched command on the memory port
  // DONE  | granted port's ready strobe, read data returned
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          rdy0;
  logic          rdy1;
  logic          pick;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    pick = 1'b0;
    if (p0_valid && p1_valid) begin
      pick = ~last_grant;
    end else if (p1_valid) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdy0       <= 1'b0;
      rdy1       <= 1'b0;
    end else begin
      rdy0 <= 1'b0;
      rdy1 <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_valid || p1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            lat_we     <= pick ? p1_we    : p0_we;
            lat_addr   <= pick ? p1_addr  : p0_addr;
            lat_wdata  <= pick ? p1_wdata : p0_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rdy0  <= ~grant;
          rdy1  <= grant;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Reset is gated in so a write caught by reset in ISSUE never lands.
  assign mem_wen   = (state == ISSUE) && lat_we && !reset;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign p0_ready  = rdy0;
  assign p1_ready  = rdy1;
  assign p0_rdata  = rdy0 ? mem_rdata : '0;
  assign p1_rdata  = rdy1 ? mem_rdata : '0;
  assign busy      = (state != IDLE);

endmodule
